// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, error codes and timing helper
package ps2_pkg;

    // Host transmit engine states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_state_e;

    // Reported with tx_err
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_NOCLK = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    // Whole microseconds to system clock cycles
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        longint unsigned cyc;
        cyc = (longint'(clk_hz) / 64'd1_000_000) * longint'(us);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - glitch filter and edge detector for one PS/2 line
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   line_i       raw PS/2 line level
//   level_o      filtered level (changes only when all taps agree)
//   fall_o       one-cycle pulse on filtered 1->0
//   rise_o       one-cycle pulse on filtered 0->1
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic [FILTER_LEN-1:0] taps_q;
    logic                  level_q;
    logic                  fall_q;
    logic                  rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            taps_q <= {taps_q[FILTER_LEN-2:0], line_i};
            fall_q <= 1'b0;
            rise_q <= 1'b0;
            if (&taps_q && !level_q) begin
                level_q <= 1'b1;
                rise_q  <= 1'b1;
            end else if (~|taps_q && level_q) begin
                level_q <= 1'b0;
                fall_q  <= 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter with queue, ACK check and retry
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   in_data/in_valid  command byte input; in_ready = queue not full
//   rx_busy           receiver mid-frame, holds off new transfers
//   ps2c, ps2d        open-drain PS/2 clock and data (drive 0 or z)
//   tx_done           one-cycle pulse, byte ACKed
//   tx_err, err_code  one-cycle pulse and cause, byte dropped after retries
//   busy              engine not idle
//   queue_level       bytes waiting in the queue
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
    parameter int unsigned REQUEST_US       = 120,
    parameter int unsigned FILTER_LEN       = 8,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000,
    parameter int unsigned QUEUE_DEPTH      = 4,
    parameter int unsigned MAX_RETRIES      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         rx_busy,
    inout  wire                          ps2c,
    inout  wire                          ps2d,
    output logic                         tx_done,
    output logic                         tx_err,
    output logic [1:0]                   err_code,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level
);

    localparam int unsigned REQ_CYC   = us_to_cycles(CLK_FREQ_HZ, REQUEST_US);
    localparam int unsigned START_CYC = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned FRAME_CYC = us_to_cycles(CLK_FREQ_HZ, FRAME_TIMEOUT_US);
    localparam int unsigned MAX_RS    = (REQ_CYC > START_CYC) ? REQ_CYC : START_CYC;
    localparam int unsigned MAX_CYC   = (MAX_RS > FRAME_CYC) ? MAX_RS : FRAME_CYC;
    localparam int          CNT_W     = $clog2(MAX_CYC + 1);
    localparam int          AW        = $clog2(QUEUE_DEPTH);
    localparam int          ATT_W     = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] REQ_LAST   = CNT_W'(REQ_CYC - 1);
    localparam logic [CNT_W-1:0] REQ_DATA   = CNT_W'(REQ_CYC - 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [ATT_W-1:0] MAX_ATT    = ATT_W'(MAX_RETRIES);
    localparam logic [AW:0]      FULL_LVL   = (AW + 1)'(QUEUE_DEPTH);

    // Line filters
    logic c_level, c_fall, c_rise;
    logic d_level, d_fall, d_rise;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk     (clk),
        .rst_n   (reset),
        .line_i  (ps2c),
        .level_o (c_level),
        .fall_o  (c_fall),
        .rise_o  (c_rise)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk     (clk),
        .rst_n   (reset),
        .line_i  (ps2d),
        .level_o (d_level),
        .fall_o  (d_fall),
        .rise_o  (d_rise)
    );

    logic unused_edges;
    assign unused_edges = c_rise ^ d_fall ^ d_rise;

    // Byte queue
    logic [7:0]    mem_q [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [8:0]       frame_q;
    logic [3:0]       bit_idx_q;
    logic [ATT_W-1:0] attempt_q;
    logic             drive_c_q;
    logic             drive_d_q;
    logic             tx_done_q;
    logic             tx_err_q;
    logic [1:0]       err_code_q;

    assign in_ready = (count_q != FULL_LVL);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_IDLE) && (count_q != '0) && !rx_busy && c_level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Attempt failure detection; a device clock edge wins over a same-cycle timeout
    logic       fail;
    logic [1:0] fail_code;

    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (state_q)
            ST_START: begin
                if (!c_fall && cnt_q == START_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOCLK;
                end
            end
            ST_DATA: begin
                if (!c_fall && cnt_q == FRAME_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_FRAME;
                end
            end
            ST_ACK: begin
                if (c_fall && d_level) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOACK;
                end else if (!c_fall && cnt_q == FRAME_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_FRAME;
                end
            end
            ST_RELEASE: begin
                if (!(c_level && d_level) && cnt_q == FRAME_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_FRAME;
                end
            end
            default: ;
        endcase
    end

    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       next_idx;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign next_idx = bit_idx_q + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            bit_idx_q  <= '0;
            attempt_q  <= '0;
            drive_c_q  <= 1'b0;
            drive_d_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
            if (fail) begin
                drive_c_q <= 1'b0;
                drive_d_q <= 1'b0;
                cnt_q     <= '0;
                if (attempt_q < MAX_ATT) begin
                    attempt_q <= attempt_q + ATT_W'(1);
                    state_q   <= ST_REQUEST;
                end else begin
                    tx_err_q   <= 1'b1;
                    err_code_q <= fail_code;
                    state_q    <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop) begin
                            frame_q   <= {~^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
                            attempt_q <= '0;
                            cnt_q     <= '0;
                            drive_c_q <= 1'b1;
                            state_q   <= ST_REQUEST;
                        end
                    end
                    ST_REQUEST: begin
                        // Only cycles with the clock actually held low count, so a
                        // retry entering with the clock released gets the full hold.
                        if (!drive_c_q) begin
                            drive_c_q <= 1'b1;
                        end else if (cnt_q == REQ_LAST) begin
                            drive_c_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_START;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_q == REQ_DATA) drive_d_q <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (c_fall) begin
                            drive_d_q <= ~frame_q[0];
                            bit_idx_q <= '0;
                            cnt_q     <= '0;
                            state_q   <= ST_DATA;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ST_DATA: begin
                        cnt_q <= cnt_inc;
                        if (c_fall) begin
                            if (bit_idx_q == 4'd8) begin
                                drive_d_q <= 1'b0;
                                state_q   <= ST_ACK;
                            end else begin
                                bit_idx_q <= next_idx;
                                drive_d_q <= ~frame_q[next_idx];
                            end
                        end
                    end
                    ST_ACK: begin
                        cnt_q <= cnt_inc;
                        if (c_fall) state_q <= ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        cnt_q <= cnt_inc;
                        if (c_level && d_level) begin
                            tx_done_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ps2c        = drive_c_q ? 1'b0 : 1'bz;
    assign ps2d        = drive_d_q ? 1'b0 : 1'bz;
    assign tx_done     = tx_done_q;
    assign tx_err      = tx_err_q;
    assign err_code    = err_code_q;
    assign busy        = (state_q != ST_IDLE);
    assign queue_level = count_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx
module tb_ps2_host_tx;

    localparam int REQ_CYC   = 120;
    localparam int START_CYC = 400;
    localparam int HALF      = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       rx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] queue_level;
    logic       dev_c;
    logic       dev_d;
    wire        ps2c;
    wire        ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (1_000_000),
        .REQUEST_US       (120),
        .FILTER_LEN       (8),
        .START_TIMEOUT_US (400),
        .FRAME_TIMEOUT_US (600),
        .QUEUE_DEPTH      (4),
        .MAX_RETRIES      (2)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rx_busy     (rx_busy),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code),
        .busy        (busy),
        .queue_level (queue_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_lvl [32];

    always @(negedge clk) begin
        if (tx_done) begin
            if (done_cnt < 32) done_lvl[done_cnt] = int'(queue_level);
            done_cnt++;
        end
        if (tx_err) err_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Device side: waits for request-to-send, clocks nclk pulses, samples data
    // after each rising edge; bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_frame(input bit ack, input int nclk, input bit glitch,
                             output logic [10:0] bits, output bit ok);
        int w;
        bits = '0;
        ok   = 1'b0;
        w    = 0;
        while (!(ps2c === 1'b1 && ps2d === 1'b0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) return;
        ok = 1'b1;
        repeat (HALF) @(negedge clk);
        bits[0] = ps2d;
        for (int k = 1; k <= nclk; k++) begin
            dev_c = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c = 1'b0;
            repeat (HALF/2) @(negedge clk);
            if (k <= 10) bits[k] = ps2d;
            if (k == 10 && ack) dev_d = 1'b1;
            if (glitch && k <= 9) begin
                dev_c = 1'b1;
                repeat (3) @(negedge clk);
                dev_c = 1'b0;
                repeat (HALF/2 - 3) @(negedge clk);
            end else begin
                repeat (HALF/2) @(negedge clk);
            end
        end
        dev_d = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int w;
        w = 0;
        while (done_cnt < target && w < 300) begin
            @(negedge clk);
            w++;
        end
        check(tag, done_cnt, target);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          n;
        int          w;
        int          d0;
        int          e0;
        logic [7:0]  q5 [4];
        logic [10:0] f5 [4];
        logic [7:0]  q3 [3];
        logic [10:0] f3 [3];

        q5 = '{8'h11, 8'h22, 8'h33, 8'h44};
        f5 = '{11'h622, 11'h644, 11'h666, 11'h688};
        q3 = '{8'h01, 8'h00, 8'hFF};
        f3 = '{11'h402, 11'h600, 11'h7FE};

        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        rx_busy  = 1'b0;
        dev_c    = 1'b0;
        dev_d    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_level", int'(queue_level), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_err", int'(tx_err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_ps2c", int'(ps2c), 1);
        check("rst_ps2d", int'(ps2d), 1);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single byte 0xED: latency, request hold, frame bits, ACK
        push(8'hED);
        n = 1;
        while (ps2c !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_latency", n, 2);
        n = 0;
        while (ps2c === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("req_low_cycles", n, REQ_CYC);
        dev_frame(1'b1, 11, 1'b0, bits, ok);
        check("ed_req_seen", int'(ok), 1);
        check("ed_bits", int'(bits), 32'h7DA);
        wait_done("ed_done", 1);
        repeat (5) @(negedge clk);
        check("ed_level", int'(queue_level), 0);
        check("ed_busy", int'(busy), 0);

        // Three bytes queued, then sent in order
        d0 = done_cnt;
        rx_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(q3[i]);
        check("q3_level", int'(queue_level), 3);
        rx_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dev_frame(1'b1, 11, 1'b0, bits, ok);
            check($sformatf("q3_bits%0d", i), int'(bits), int'(f3[i]));
            wait_done($sformatf("q3_done%0d", i), d0 + i + 1);
            check($sformatf("q3_lvl%0d", i), done_lvl[d0 + i], 2 - i);
        end

        // Device never clocks: three attempts then ERR_NOCLK
        d0 = done_cnt;
        e0 = err_cnt;
        push(8'h12);
        for (int a = 0; a < 3; a++) begin
            w = 0;
            while (ps2c !== 1'b0 && w < 1000) begin
                @(negedge clk);
                w++;
            end
            w = 0;
            while (ps2c !== 1'b1 && w < 1000) begin
                @(negedge clk);
                w++;
            end
            n = 1;
            while (n < 2000) begin
                @(negedge clk);
                if (ps2c === 1'b0) break;
                n++;
                if (tx_err) break;
            end
            check($sformatf("noclk_start_len%0d", a), n, START_CYC + 1);
        end
        repeat (3) @(negedge clk);
        check("noclk_err_cnt", err_cnt, e0 + 1);
        check("noclk_code", int'(err_code), 1);
        check("noclk_ps2c", int'(ps2c), 1);
        check("noclk_ps2d", int'(ps2d), 1);
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (ps2c === 1'b0) n++;
        end
        check("noclk_no_4th", n, 0);
        check("noclk_no_done", done_cnt, d0);

        // NAK on first attempt, ACK on retry
        d0 = done_cnt;
        e0 = err_cnt;
        push(8'hF0);
        dev_frame(1'b0, 11, 1'b0, bits, ok);
        check("nak_bits1", int'(bits), 32'h7E0);
        dev_frame(1'b1, 11, 1'b0, bits, ok);
        check("nak_bits2", int'(bits), 32'h7E0);
        wait_done("nak_done", d0 + 1);
        repeat (100) @(negedge clk);
        check("nak_one_done", done_cnt, d0 + 1);
        check("nak_no_err", err_cnt, e0);
        check("nak_code_held", int'(err_code), 1);

        // Full queue while stalled; fifth byte dropped
        d0 = done_cnt;
        rx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(q5[i]);
        check("full_ready", int'(in_ready), 0);
        check("full_level", int'(queue_level), 4);
        push(8'h55);
        check("full_level_5th", int'(queue_level), 4);
        rx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dev_frame(1'b1, 11, 1'b0, bits, ok);
            check($sformatf("full_bits%0d", i), int'(bits), int'(f5[i]));
            wait_done($sformatf("full_done%0d", i), d0 + i + 1);
        end
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (ps2c === 1'b0) n++;
        end
        check("full_no_5th", n, 0);
        check("full_level_end", int'(queue_level), 0);

        // Reset mid-DATA
        push(8'h00);
        push(8'h77);
        dev_frame(1'b1, 4, 1'b0, bits, ok);
        check("rstm_ok", int'(ok), 1);
        check("rstm_pre_d", int'(ps2d), 0);
        check("rstm_pre_lvl", int'(queue_level), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("rstm_ps2c", int'(ps2c), 1);
        check("rstm_ps2d", int'(ps2d), 1);
        check("rstm_level", int'(queue_level), 0);
        check("rstm_ready", int'(in_ready), 1);
        check("rstm_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rstm_no_done", done_cnt, d0);
        check("rstm_no_err", err_cnt, e0);
        check("rstm_idle_c", int'(ps2c), 1);
        push(8'h5A);
        dev_frame(1'b1, 11, 1'b0, bits, ok);
        check("rstm_after_bits", int'(bits), 32'h6B4);
        wait_done("rstm_after_done", d0 + 1);

        // Short clock glitches during DATA
        d0 = done_cnt;
        push(8'hA5);
        dev_frame(1'b1, 11, 1'b1, bits, ok);
        check("glitch_bits", int'(bits), 32'h74A);
        wait_done("glitch_done", d0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter with a byte queue, ACK checking, timeouts and automatic retry.
- Accepts command bytes over a valid/ready interface into a FIFO.
- For each byte: drives the PS/2 request-to-send sequence, shifts out the 11-bit frame on device clock edges and checks the device ACK bit.
- Reports per-byte completion or error to the keyboard controller. Sits beside the PS/2 receiver on the shared ps2c/ps2d lines.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- REQUEST_US, 120, duration ps2c is held low for request-to-send.
- FILTER_LEN, 8, ps2c/ps2d glitch-filter length in clk cycles.
- START_TIMEOUT_US, 15000, max time from clock release to first device falling edge.
- FRAME_TIMEOUT_US, 2000, max time from first falling edge to ACK.
- QUEUE_DEPTH, 4, FIFO depth in bytes; must be a power of 2, minimum 2.
- MAX_RETRIES, 2, re-send attempts after a failed attempt before the byte is dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  byte to send
- in_valid  in  1  in_data valid
- in_ready  out  1  queue can accept; equals not-full
- rx_busy  in  1  receiver mid-frame; blocks starting a new transfer
- ps2c  inout  1  PS/2 clock, open-drain (drives 0 or z)
- ps2d  inout  1  PS/2 data, open-drain (drives 0 or z)
- tx_done  out  1  one-cycle pulse: byte ACKed by device
- tx_err  out  1  one-cycle pulse: byte dropped after retries exhausted
- err_code  out  2  valid with tx_err: 01 no clock, 10 frame timeout, 11 no ACK; held until the next tx_err
- busy  out  1  high in any state other than IDLE
- queue_level  out  $clog2(QUEUE_DEPTH)+1  bytes held in the queue

Behaviour:
- Reset state (while reset is low):
  - ps2c and ps2d released (z) immediately and asynchronously.
  - Queue emptied; in_ready=1; tx_done=0, tx_err=0, err_code=0, busy=0, queue_level=0.
  - State=IDLE; filters preset to 1.
- Reset mid-frame aborts silently: no tx_done or tx_err pulse.
- Lines are never driven high; a logic 1 is always z.
- Filtering: ps2c and ps2d each pass through FILTER_LEN shift registers. The filtered value changes only when all taps agree.
  - fall = filtered ps2c goes 1->0; rise = filtered ps2c goes 0->1. Each is a one-cycle pulse.
- Queue:
  - Push when in_valid & in_ready.
  - Push and pop in the same cycle both take effect.
  - A push into an empty queue is first seen by IDLE on the next cycle.
  - in_ready is low when full, even if a pop occurs that cycle.
- Cycle counts: REQ_CYC = CLK_FREQ_HZ/1e6*REQUEST_US; likewise for both timeouts. One shared counter, width sized from the largest count.
- States:
  - IDLE: if queue non-empty and !rx_busy and filtered ps2c=1, latch {odd parity, byte} plus the attempt count, pop the queue, clear the counter, go to REQUEST.
  - REQUEST: drive ps2c=0 for REQ_CYC cycles. In the last cycle also drive ps2d=0. Go to START with the counter cleared.
  - START: release ps2c, hold ps2d=0 (start bit).
    - On fall: drive data bit0, bit index=0, counter cleared, go to DATA.
    - If counter reaches the start timeout: error 01.
  - DATA: drive the current bit (0 -> drive 0, 1 -> z).
    - On each fall, advance to the next bit: data0..data7, then parity.
    - On the fall after parity: release ps2d (stop bit), go to ACK.
  - ACK: ps2d released. On the next fall, sample filtered ps2d.
    - 0: go to RELEASE.
    - 1: error 11.
  - RELEASE: wait until filtered ps2c=1 and ps2d=1, then pulse tx_done and go to IDLE.
- Frame timeout: measured from DATA entry through ACK and RELEASE. Expiry -> error 10.
- Error handling:
  - Release both lines.
  - If attempts < MAX_RETRIES: increment attempts and go to REQUEST with the same latched byte. Not re-queued; no pulse.
  - Otherwise: pulse tx_err, set err_code, go to IDLE.
- Line contention: the block never drives both lines low except in the final REQUEST cycle. Only one line changes per cycle.
- Latency from IDLE detecting the byte to ps2c low: 1 cycle.

Decomposition:
- Package ps2_pkg holds:
  - state encoding (IDLE, REQUEST, START, DATA, ACK, RELEASE);
  - err_code constants ERR_NONE=00, ERR_NOCLK=01, ERR_FRAME=10, ERR_NOACK=11;
  - a us-to-cycles constant function.
- Sub-module ps2_line_filter: one instance per line, parameter FILTER_LEN, outputs filtered level, fall and rise. The receiver shares it.
- The FIFO is inline.

Test Plan:
- Device model at a 12.5 kHz clock; push 0xED:
  - ps2c held low for exactly 12000 cycles;
  - bits sent on data edges: 0, 1,0,1,1,0,1,1,1, 1, stop z;
  - model ACKs; tx_done pulses once and the queue empties.
- Push 0x01, 0x00, 0xFF back-to-back (QUEUE_DEPTH=4):
  - parity bits 0, 1, 1;
  - three tx_done pulses in order; queue_level goes 3->2->1->0.
- Model never clocks after the request:
  - three attempts, each 15000 us after clock release;
  - then tx_err with err_code=01, and both lines at z.
- Model NAKs (ps2d=1 at the ACK edge) on attempt 1, ACKs on attempt 2: no tx_err, exactly one tx_done.
- Fill the queue (4 bytes) with the engine stalled by rx_busy=1: in_ready=0 and a 5th in_valid is ignored. Release rx_busy: all 4 bytes are sent.
- Assert reset mid-DATA: ps2c/ps2d are z in the same cycle, no pulses, queue_level=0, and a byte pushed after reset is sent normally.
- Inject 3-cycle glitches on ps2c during DATA: no bit advance.
